// File: rtl/apb_controller.sv
// apb_controller: APB master sequencer of an AHB-to-APB bridge.
// Turns decoded AHB transfers into APB SETUP/ENABLE phases. It handles single
// reads, single writes and back-to-back pipelined writes, and pulls Hreadyout
// low while a setup phase is being issued.
//
// Optional feature (compile-time macro APB_IDLE_CLEAR_EN):
//   defined     - a quiet bus cycle also clears Paddr, Pwdata and Pwrite
//   not defined - Paddr, Pwdata and Pwrite keep their last values while quiet
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no APB activity, AHB not stalled
// READ     | read SETUP phase on APB (Pselx up, Penable low)
// RENABLE  | read ENABLE phase on APB
// WWAIT    | write seen on AHB, waiting one cycle for its data phase
// WRITE    | write SETUP phase, no further transfer pending
// WRITEP   | write SETUP phase, another transfer already pending
// WENABLE  | write ENABLE phase, no further transfer pending
// WENABLEP | write ENABLE phase, pipelined transfer pending
module apb_controller #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SEL_W  = 3
) (
   input  logic              Hclk,
   input  logic              Hresetn,
   input  logic              valid,
   input  logic              Hwrite,
   input  logic              Hwritereg,
   input  logic [ADDR_W-1:0] Haddr,
   input  logic [ADDR_W-1:0] Haddr1,
   input  logic [ADDR_W-1:0] Haddr2,
   input  logic [DATA_W-1:0] Hwdata,
   input  logic [DATA_W-1:0] Hwdata1,
   input  logic [DATA_W-1:0] Hwdata2,
   input  logic [DATA_W-1:0] Prdata,
   input  logic [SEL_W-1:0]  tempselx,
   output logic              Pwrite,
   output logic              Penable,
   output logic [SEL_W-1:0]  Pselx,
   output logic [ADDR_W-1:0] Paddr,
   output logic [DATA_W-1:0] Pwdata,
   output logic              Hreadyout
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_RENABLE  = 3'd2,
      ST_WWAIT    = 3'd3,
      ST_WRITE    = 3'd4,
      ST_WRITEP   = 3'd5,
      ST_WENABLE  = 3'd6,
      ST_WENABLEP = 3'd7
   } state_t;

   state_t present_state;
   state_t next_state;

   // Hwdata2 is carried by the bridge datapath only; read data returns to AHB
   // outside this block. Both are folded here so they are visibly consumed.
   logic unused_ok;
   assign unused_ok = ^{Hwdata2, Prdata};

   // Next-state selection from the current phase and the AHB-side qualifiers.
   always_comb begin
      next_state = present_state;
      case (present_state)
         ST_IDLE, ST_RENABLE, ST_WENABLE: begin
            if (!valid)
               next_state = ST_IDLE;
            else if (Hwrite)
               next_state = ST_WWAIT;
            else
               next_state = ST_READ;
         end
         ST_READ:   next_state = ST_RENABLE;
         ST_WWAIT:  next_state = valid ? ST_WRITEP : ST_WRITE;
         ST_WRITE:  next_state = valid ? ST_WENABLEP : ST_WENABLE;
         ST_WRITEP: next_state = ST_WENABLEP;
         ST_WENABLEP: begin
            if (!Hwritereg)
               next_state = ST_READ;
            else if (valid)
               next_state = ST_WRITEP;
            else
               next_state = ST_WRITE;
         end
         default:   next_state = ST_IDLE;
      endcase
   end

   // State register plus registered APB outputs. The outputs are decided from
   // the present state, so they line up with the state they describe.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         present_state <= ST_IDLE;
         Paddr         <= '0;
         Pwdata        <= '0;
         Pwrite        <= 1'b0;
         Pselx         <= '0;
         Penable       <= 1'b0;
         Hreadyout     <= 1'b1;
      end else begin
         present_state <= next_state;
         case (present_state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
               if (valid && !Hwrite) begin
                  Paddr     <= Haddr;
                  Pwrite    <= 1'b0;
                  Pselx     <= tempselx;
                  Penable   <= 1'b0;
                  Hreadyout <= 1'b0;
               end else begin
                  Pselx     <= '0;
                  Penable   <= 1'b0;
                  Hreadyout <= 1'b1;
`ifdef APB_IDLE_CLEAR_EN
                  Paddr     <= '0;
                  Pwdata    <= '0;
                  Pwrite    <= 1'b0;
`endif
               end
            end
            ST_READ, ST_WRITE, ST_WRITEP: begin
               Penable   <= 1'b1;
               Hreadyout <= 1'b1;
            end
            ST_WWAIT: begin
               // address phase was one cycle earlier, data is on the bus now
               Paddr     <= Haddr1;
               Pwdata    <= Hwdata;
               Pwrite    <= 1'b1;
               Pselx     <= tempselx;
               Penable   <= 1'b0;
               Hreadyout <= 1'b0;
            end
            ST_WENABLEP: begin
               if (Hwritereg) begin
                  // pipelined write: address two stages back, data one stage back
                  Paddr     <= Haddr2;
                  Pwdata    <= Hwdata1;
                  Pwrite    <= 1'b1;
                  Pselx     <= tempselx;
                  Penable   <= 1'b0;
                  Hreadyout <= 1'b0;
               end else begin
                  Paddr     <= Haddr;
                  Pwrite    <= 1'b0;
                  Pselx     <= tempselx;
                  Penable   <= 1'b0;
                  Hreadyout <= 1'b0;
               end
            end
            default: begin
               Pselx     <= '0;
               Penable   <= 1'b0;
               Hreadyout <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_controller.sv
// Testbench for apb_controller: directed bridge scenarios followed by random
// AHB-side traffic, all checked against a phase-level reference model.
module tb_apb_controller;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 3;

   logic              Hclk = 1'b0;
   logic              Hresetn;
   logic              valid, Hwrite, Hwritereg;
   logic [ADDR_W-1:0] Haddr, Haddr1, Haddr2;
   logic [DATA_W-1:0] Hwdata, Hwdata1, Hwdata2, Prdata;
   logic [SEL_W-1:0]  tempselx;
   logic              Pwrite, Penable, Hreadyout;
   logic [SEL_W-1:0]  Pselx;
   logic [ADDR_W-1:0] Paddr;
   logic [DATA_W-1:0] Pwdata;

   apb_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
      .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Hwrite(Hwrite),
      .Hwritereg(Hwritereg), .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2),
      .Hwdata(Hwdata), .Hwdata1(Hwdata1), .Hwdata2(Hwdata2), .Prdata(Prdata),
      .tempselx(tempselx), .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx),
      .Paddr(Paddr), .Pwdata(Pwdata), .Hreadyout(Hreadyout)
   );

   always #5 Hclk = ~Hclk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: tracks the bridge phase and the expected APB bus view.
   // Bus activity is keyed by the phase being entered: entering a setup phase
   // launches a transfer, entering an enable phase raises Penable, anything
   // else is a quiet cycle.
   typedef enum int {M_IDLE, M_READ, M_RENABLE, M_WWAIT, M_WRITE, M_WRITEP,
                     M_WENABLE, M_WENABLEP} mphase_t;
   mphase_t     m_ph;
   logic [31:0] e_paddr, e_pwdata;
   logic [2:0]  e_psel;
   logic        e_pwrite, e_penable, e_hready;

   task automatic model_reset();
      m_ph      = M_IDLE;
      e_paddr   = '0;
      e_pwdata  = '0;
      e_pwrite  = 1'b0;
      e_psel    = '0;
      e_penable = 1'b0;
      e_hready  = 1'b1;
   endtask

   task automatic model_step();
      mphase_t nx;
      nx = M_IDLE;
      case (m_ph)
         M_IDLE, M_RENABLE, M_WENABLE:
            nx = !valid ? M_IDLE : (Hwrite ? M_WWAIT : M_READ);
         M_READ:     nx = M_RENABLE;
         M_WWAIT:    nx = valid ? M_WRITEP : M_WRITE;
         M_WRITE:    nx = valid ? M_WENABLEP : M_WENABLE;
         M_WRITEP:   nx = M_WENABLEP;
         M_WENABLEP: nx = !Hwritereg ? M_READ : (valid ? M_WRITEP : M_WRITE);
         default:    nx = M_IDLE;
      endcase
      case (nx)
         M_READ: begin
            e_paddr = Haddr; e_pwrite = 1'b0; e_psel = tempselx;
            e_penable = 1'b0; e_hready = 1'b0;
         end
         M_WRITE, M_WRITEP: begin
            if (m_ph == M_WWAIT) begin
               e_paddr = Haddr1; e_pwdata = Hwdata;
            end else begin
               e_paddr = Haddr2; e_pwdata = Hwdata1;
            end
            e_pwrite = 1'b1; e_psel = tempselx; e_penable = 1'b0; e_hready = 1'b0;
         end
         M_RENABLE, M_WENABLE, M_WENABLEP: begin
            e_penable = 1'b1; e_hready = 1'b1;
         end
         default: begin
            e_psel = '0; e_penable = 1'b0; e_hready = 1'b1;
`ifdef APB_IDLE_CLEAR_EN
            e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0;
`endif
         end
      endcase
      m_ph = nx;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".Paddr"},     Paddr,     e_paddr);
      chk({tag, ".Pwdata"},    Pwdata,    e_pwdata);
      chk({tag, ".Pwrite"},    {31'b0, Pwrite},    {31'b0, e_pwrite});
      chk({tag, ".Pselx"},     {29'b0, Pselx},     {29'b0, e_psel});
      chk({tag, ".Penable"},   {31'b0, Penable},   {31'b0, e_penable});
      chk({tag, ".Hreadyout"}, {31'b0, Hreadyout}, {31'b0, e_hready});
   endtask

   // One clock: model consumes the inputs present at the edge, DUT is sampled 1ns later.
   task automatic tick(input string tag);
      model_step();
      @(posedge Hclk);
      #1;
      chk_model(tag);
   endtask

   task automatic set_in(input logic v, input logic w, input logic wr);
      valid = v; Hwrite = w; Hwritereg = wr;
   endtask

   initial begin
      Hresetn = 1'b0;
      set_in(1'b0, 1'b0, 1'b0);
      Haddr = '0; Haddr1 = '0; Haddr2 = '0;
      Hwdata = '0; Hwdata1 = '0; Hwdata2 = '0; Prdata = '0;
      tempselx = 3'b001;
      model_reset();

      // reset values
      #12;
      chk_model("reset");
      chk("reset.Hreadyout", {31'b0, Hreadyout}, 32'd1);
      chk("reset.Paddr", Paddr, 32'd0);
      @(negedge Hclk);
      Hresetn = 1'b1;
      @(posedge Hclk); #1;
      tick("post_reset_idle");

      // single read
      set_in(1'b1, 1'b0, 1'b0);
      Haddr = 32'h8100_0000; tempselx = 3'b001;
      tick("rd_setup");
      chk("rd_setup.Paddr", Paddr, 32'h8100_0000);
      chk("rd_setup.Hreadyout", {31'b0, Hreadyout}, 32'd0);
      set_in(1'b0, 1'b0, 1'b0);
      tick("rd_enable");
      chk("rd_enable.Penable", {31'b0, Penable}, 32'd1);
      tick("rd_idle");

      // single write
      set_in(1'b1, 1'b1, 1'b0);
      Haddr1 = 32'h8200_0000; Hwdata = 32'd32;
      tick("wr_wait");
      set_in(1'b0, 1'b0, 1'b0);
      tick("wr_setup");
      chk("wr_setup.Paddr", Paddr, 32'h8200_0000);
      chk("wr_setup.Pwdata", Pwdata, 32'h20);
      chk("wr_setup.Pwrite", {31'b0, Pwrite}, 32'd1);
      tick("wr_enable");
      tick("wr_idle");

      // burst write
      set_in(1'b1, 1'b1, 1'b1);
      Haddr1 = 32'h8200_0000; Haddr2 = 32'h8300_0000;
      Hwdata = 32'd32; Hwdata1 = 32'd45;
      tick("bw_wait");
      tick("bw_setup1");
      chk("bw_setup1.Paddr", Paddr, 32'h8200_0000);
      tick("bw_enable1");
      tick("bw_setup2");
      chk("bw_setup2.Paddr", Paddr, 32'h8300_0000);
      chk("bw_setup2.Pwdata", Pwdata, 32'h2D);
      tick("bw_enable2");
      set_in(1'b0, 1'b1, 1'b1);
      tick("bw_last_setup");
      chk("bw_last_setup.Hreadyout", {31'b0, Hreadyout}, 32'd0);
      tick("bw_last_enable");
      tick("bw_idle");

      // write followed by read
      set_in(1'b1, 1'b1, 1'b1);
      tick("wtr_wait");
      tick("wtr_setup");
      tick("wtr_enable");
      set_in(1'b1, 1'b0, 1'b0);
      Haddr = 32'h8400_0000; tempselx = 3'b010;
      tick("wtr_read");
      chk("wtr_read.Paddr", Paddr, 32'h8400_0000);
      chk("wtr_read.Pwrite", {31'b0, Pwrite}, 32'd0);
      set_in(1'b0, 1'b0, 1'b0);
      tick("wtr_renable");
      tick("wtr_idle");

      // async reset in the middle of a burst
      set_in(1'b1, 1'b1, 1'b1);
      tempselx = 3'b100;
      tick("ar_wait");
      tick("ar_setup");
      tick("ar_enable");
      #2;
      Hresetn = 1'b0;
      model_reset();
      #1;
      chk_model("ar_reset");
      chk("ar_reset.Penable", {31'b0, Penable}, 32'd0);
      set_in(1'b0, 1'b0, 1'b0);
      @(negedge Hclk);
      Hresetn = 1'b1;
      @(posedge Hclk); #1;
      tick("ar_idle");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         valid     = ($urandom_range(0, 9) < 7);
         Hwrite    = $urandom_range(0, 1) == 1;
         Hwritereg = $urandom_range(0, 3) != 0;
         Haddr     = $urandom; Haddr1 = $urandom; Haddr2 = $urandom;
         Hwdata    = $urandom; Hwdata1 = $urandom; Hwdata2 = $urandom;
         Prdata    = $urandom;
         case ($urandom_range(0, 2))
            0:       tempselx = 3'b001;
            1:       tempselx = 3'b010;
            default: tempselx = 3'b100;
         endcase
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
